// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the DMA arbiter, the CPU hold handshake and timing control.
// slave = arbiter side; master = environment driving requests and HLDA.
interface dma_priority_arbiter_if #(
  parameter int CHANNELS = 4,
  parameter int CHW      = 2
);
  logic [CHANNELS-1:0] DREQ;
  logic [CHANNELS-1:0] swRequest;
  logic [CHANNELS-1:0] maskBits;
  logic                ctrlDisable;
  logic                rotatePri;
  logic                dreqSenseLow;
  logic                dackSenseHigh;
  logic                HLDA;
  logic                serviceDone;
  logic                EOP_N;
  logic                HRQ;
  logic [CHANNELS-1:0] DACK;
  logic                grantValid;
  logic [CHW-1:0]      activeChannel;

  modport slave (
    input  DREQ, swRequest, maskBits, ctrlDisable, rotatePri, dreqSenseLow, dackSenseHigh,
    input  HLDA, serviceDone, EOP_N,
    output HRQ, DACK, grantValid, activeChannel
  );

  modport master (
    output DREQ, swRequest, maskBits, ctrlDisable, rotatePri, dreqSenseLow, dackSenseHigh,
    output HLDA, serviceDone, EOP_N,
    input  HRQ, DACK, grantValid, activeChannel
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Picks one DMA channel (fixed/rotating), runs HRQ/HLDA, drives DACK; HRQ one edge after request,
// DACK/grantValid one edge after HLDA. No backpressure: HRQ is held until HLDA, service end or abort.
module dma_priority_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CHW      = 2
) (
  input logic                    CLK,
  input logic                    RESET,
  dma_priority_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] dack_oh_q, dack_oh_d;
  logic                hrq_q, hrq_d;
  logic                grant_vld_q, grant_vld_d;
  logic [CHW-1:0]      active_q, active_d;
  logic [CHW-1:0]      ptr_q, ptr_d;
  logic [CHW-1:0]      ptr_next;
  logic [CHW-1:0]      winner;
  logic [CHW-1:0]      base;
  logic [CHW-1:0]      idx;
  logic                found;
  logic                normal_end;

  assign req = ~bus.maskBits & ((bus.DREQ ^ {CHANNELS{bus.dreqSenseLow}}) | bus.swRequest);

  // Search starts at the pointer in rotating mode, at channel 0 in fixed mode.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    base   = bus.rotatePri ? ptr_q : '0;
    for (int off = 0; off < CHANNELS; off++) begin
      idx = CHW'((int'(base) + off) % CHANNELS);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign ptr_next   = (active_q == CHW'(CHANNELS - 1)) ? '0 : active_q + CHW'(1);
  assign normal_end = bus.serviceDone || !bus.EOP_N;

  always_comb begin
    state_d     = state_q;
    hrq_d       = hrq_q;
    grant_vld_d = 1'b0;
    dack_oh_d   = dack_oh_q;
    active_d    = active_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        hrq_d     = 1'b0;
        dack_oh_d = '0;
        if (!bus.ctrlDisable && found) begin
          active_d = winner;
          hrq_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        hrq_d = 1'b1;
        if (bus.HLDA) begin
          grant_vld_d = 1'b1;
          dack_oh_d   = CHANNELS'(1) << active_q;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Losing HLDA wins over a coincident serviceDone/EOP: no pointer update.
        if (!bus.HLDA) begin
          hrq_d     = 1'b0;
          dack_oh_d = '0;
          state_d   = IDLE;
        end else if (normal_end) begin
          hrq_d     = 1'b0;
          dack_oh_d = '0;
          ptr_d     = ptr_next;
          state_d   = IDLE;
        end
      end
      default: begin
        hrq_d     = 1'b0;
        dack_oh_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      hrq_q       <= 1'b0;
      grant_vld_q <= 1'b0;
      dack_oh_q   <= '0;
      active_q    <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      hrq_q       <= hrq_d;
      grant_vld_q <= grant_vld_d;
      dack_oh_q   <= dack_oh_d;
      active_q    <= active_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.HRQ           = hrq_q;
  assign bus.grantValid    = grant_vld_q;
  assign bus.activeChannel = active_q;
  assign bus.DACK          = bus.dackSenseHigh ? dack_oh_q : ~dack_oh_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter: expected winners queued at request time,
// checked against activeChannel/DACK when grantValid pulses.
module tb_dma_priority_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_q[$];

  dma_priority_arbiter_if #(.CHANNELS(4), .CHW(2)) bus ();

  dma_priority_arbiter #(.CHANNELS(4), .CHW(2)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] dack_exp(input int ch, input logic sense_high);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    return sense_high ? oh : ~oh;
  endfunction

  function automatic logic [3:0] dack_idle(input logic sense_high);
    return sense_high ? 4'b0000 : 4'b1111;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.grantValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_grant", 32'd1, 32'd0);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("grant_ch", 32'(bus.activeChannel), 32'(e));
        chk("grant_dack", 32'(bus.DACK), 32'(dack_exp(e, bus.dackSenseHigh)));
      end
    end
  end

  // end_mode: 0 = serviceDone, 1 = EOP_N low, 2 = HLDA dropped (abort)
  task automatic run_service(input logic [3:0] dreq_raw, input int exp_ch,
                             input int hlda_delay, input int end_mode);
    bus.DREQ = dreq_raw;
    exp_q.push_back(exp_ch);
    tick();
    chk("hrq_next_edge", 32'(bus.HRQ), 32'd1);
    for (int i = 0; i < hlda_delay; i++) begin
      tick();
      chk("hrq_held", 32'(bus.HRQ), 32'd1);
      chk("no_early_grant", 32'(bus.grantValid), 32'd0);
    end
    bus.HLDA = 1'b1;
    tick();
    chk("grant_pulse", 32'(bus.grantValid), 32'd1);
    tick();
    chk("grant_single", 32'(bus.grantValid), 32'd0);
    chk("dack_hold", 32'(bus.DACK), 32'(dack_exp(exp_ch, bus.dackSenseHigh)));
    bus.DREQ = bus.dreqSenseLow ? 4'hF : 4'h0;
    case (end_mode)
      0:       bus.serviceDone = 1'b1;
      1:       bus.EOP_N = 1'b0;
      default: bus.HLDA = 1'b0;
    endcase
    tick();
    bus.serviceDone = 1'b0;
    bus.EOP_N       = 1'b1;
    bus.HLDA        = 1'b0;
    chk("hrq_release", 32'(bus.HRQ), 32'd0);
    chk("dack_release", 32'(bus.DACK), 32'(dack_idle(bus.dackSenseHigh)));
    tick();
    chk("stay_idle", 32'(bus.HRQ), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    bus.DREQ          = 4'h0;
    bus.swRequest     = 4'h0;
    bus.maskBits      = 4'h0;
    bus.ctrlDisable   = 1'b0;
    bus.rotatePri     = 1'b0;
    bus.dreqSenseLow  = 1'b0;
    bus.dackSenseHigh = 1'b1;
    bus.HLDA          = 1'b0;
    bus.serviceDone   = 1'b0;
    bus.EOP_N         = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_hrq", 32'(bus.HRQ), 32'd0);
    chk("reset_gv", 32'(bus.grantValid), 32'd0);
    chk("reset_act", 32'(bus.activeChannel), 32'd0);
    chk("reset_dack", 32'(bus.DACK), 32'h0);
    rst = 1'b0;
    tick();

    // Reset in the middle of GRANT; pointer must return to 0 (it was 3).
    bus.rotatePri = 1'b1;
    run_service(4'b0100, 2, 1, 0);
    bus.DREQ = 4'b0100;
    exp_q.push_back(2);
    tick();
    bus.HLDA = 1'b1;
    tick();
    chk("pre_reset_dack", 32'(bus.DACK), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("midgrant_rst_hrq", 32'(bus.HRQ), 32'd0);
    chk("midgrant_rst_dack", 32'(bus.DACK), 32'h0);
    chk("midgrant_rst_act", 32'(bus.activeChannel), 32'd0);
    chk("midgrant_rst_gv", 32'(bus.grantValid), 32'd0);
    bus.HLDA = 1'b0;
    bus.DREQ = 4'h0;
    tick();
    rst = 1'b0;
    tick();
    run_service(4'b1111, 0, 0, 0);

    // Fixed priority, HLDA three cycles late
    bus.rotatePri = 1'b0;
    run_service(4'b1010, 1, 3, 0);

    // Rotating: wrap from ch3 to ch0, then ch0 served puts ch3 ahead of ch0
    bus.rotatePri = 1'b1;
    run_service(4'b1000, 3, 0, 0);
    run_service(4'b1001, 0, 0, 0);
    run_service(4'b1001, 3, 0, 0);

    // Mask overrides both DREQ and software request
    bus.rotatePri = 1'b0;
    bus.maskBits  = 4'b0001;
    bus.swRequest = 4'b0001;
    tick();
    tick();
    chk("masked_no_hrq", 32'(bus.HRQ), 32'd0);
    run_service(4'b0100, 2, 1, 0);
    bus.maskBits  = 4'h0;
    bus.swRequest = 4'h0;

    // ctrlDisable blocks new arbitration
    bus.ctrlDisable = 1'b1;
    bus.DREQ = 4'b0001;
    tick();
    tick();
    chk("disabled_no_hrq", 32'(bus.HRQ), 32'd0);
    bus.ctrlDisable = 1'b0;
    run_service(4'b0001, 0, 0, 0);

    // EOP end on ch1 (pointer -> 2), abort on ch2 (pointer stays 2)
    bus.rotatePri = 1'b1;
    run_service(4'b0010, 1, 0, 1);
    run_service(4'b0100, 2, 0, 2);
    run_service(4'b0110, 2, 0, 0);

    // Inverted DREQ and DACK polarity
    bus.rotatePri     = 1'b0;
    bus.dreqSenseLow  = 1'b1;
    bus.DREQ          = 4'hF;
    bus.dackSenseHigh = 1'b0;
    tick();
    chk("lowsense_idle_dack", 32'(bus.DACK), 32'hF);
    chk("lowsense_idle_hrq", 32'(bus.HRQ), 32'd0);
    run_service(4'b1110, 0, 0, 0);

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
